// File: rtl/cl_axil_csr_pkg.sv
// Shared AXI-Lite constants, payload types and the byte-strobe merge used by
// the CSR slave and its AW/W join.
package cl_axil_csr_pkg;

  localparam int AXIL_DATA_WIDTH = 32;
  localparam int AXIL_STRB_WIDTH = 4;

  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

  typedef logic [AXIL_DATA_WIDTH-1:0] axil_data_t;
  typedef logic [AXIL_STRB_WIDTH-1:0] axil_strb_t;

  // Replace only the bytes whose strobe is set; the rest keep the current value.
  function automatic axil_data_t strb_merge(input axil_data_t cur,
                                            input axil_data_t wdata,
                                            input axil_strb_t strb);
    axil_data_t res;
    res = cur;
    for (int b = 0; b < AXIL_STRB_WIDTH; b++) begin
      if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/cl_axil_aw_w_join.sv
// Captures AW and W independently, in either order, and raises the commit
// strobe once both are held and no write response is outstanding.
module cl_axil_aw_w_join
  import cl_axil_csr_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [IDX_W-1:0] awidx,
  input  logic             awvalid,
  output logic             awready,
  input  axil_data_t       wdata,
  input  axil_strb_t       wstrb,
  input  logic             wvalid,
  output logic             wready,
  input  logic             bvalid,
  input  logic             bready,
  output logic             commit,
  output logic [IDX_W-1:0] idx,
  output axil_data_t       data,
  output axil_strb_t       strb
);

  logic aw_held;
  logic w_held;

  assign awready = !aw_held & !areset;
  assign wready  = !w_held & !areset;
  assign commit  = aw_held & w_held & !bvalid;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else if (bvalid & bready) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (awvalid & awready) aw_held <= 1'b1;
      if (wvalid & wready)   w_held  <= 1'b1;
    end
  end

  // NOTE: payload holding registers carry no reset; the held flags qualify them.
  always_ff @(posedge aclk) begin
    if (awvalid & awready) idx <= awidx;
    if (wvalid & wready) begin
      data <= wdata;
      strb <= wstrb;
    end
  end

endmodule

// File: rtl/cl_axil_csr_slave.sv
// AXI-Lite CSR bank: NUM_REGS 32-bit registers with bus read/write, per-register
// commit pulses, read-only masking and hardware update ports.
module cl_axil_csr_slave
  import cl_axil_csr_pkg::*;
#(
  parameter int                  NUM_REGS   = 16,
  parameter int                  ADDR_WIDTH = 12,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [31:0]            s_awaddr,
  input  logic                   s_awvalid,
  output logic                   s_awready,
  input  logic [31:0]            s_wdata,
  input  logic [3:0]             s_wstrb,
  input  logic                   s_wvalid,
  output logic                   s_wready,
  output logic [1:0]             s_bresp,
  output logic                   s_bvalid,
  input  logic                   s_bready,
  input  logic [31:0]            s_araddr,
  input  logic                   s_arvalid,
  output logic                   s_arready,
  output logic [31:0]            s_rdata,
  output logic [1:0]             s_rresp,
  output logic                   s_rvalid,
  input  logic                   s_rready,
  output logic [NUM_REGS*32-1:0] regs_o,
  output logic [NUM_REGS-1:0]    wr_pulse_o,
  input  logic [NUM_REGS-1:0]    hw_we_i,
  input  logic [NUM_REGS*32-1:0] hw_wdata_i
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  logic             commit;
  logic [IDX_W-1:0] w_idx;
  axil_data_t       w_data;
  axil_strb_t       w_strb;
  logic [IDX_W-1:0] ar_idx;

  axil_data_t          regs [NUM_REGS];
  logic [NUM_REGS-1:0] bus_we;
  logic                w_hit;
  logic                w_ro;
  logic                r_hit;
  axil_data_t          r_mux;

  // Address bits outside the decoded word offset are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{s_awaddr[31:ADDR_WIDTH], s_awaddr[1:0],
                         s_araddr[31:ADDR_WIDTH], s_araddr[1:0]};

  assign ar_idx    = s_araddr[ADDR_WIDTH-1:2];
  assign s_arready = !s_rvalid & !areset;

  cl_axil_aw_w_join #(.IDX_W(IDX_W)) u_join (
    .aclk    (aclk),
    .areset  (areset),
    .awidx   (s_awaddr[ADDR_WIDTH-1:2]),
    .awvalid (s_awvalid),
    .awready (s_awready),
    .wdata   (s_wdata),
    .wstrb   (s_wstrb),
    .wvalid  (s_wvalid),
    .wready  (s_wready),
    .bvalid  (s_bvalid),
    .bready  (s_bready),
    .commit  (commit),
    .idx     (w_idx),
    .data    (w_data),
    .strb    (w_strb)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    bus_we = '0;
    w_hit  = 1'b0;
    w_ro   = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_idx == IDX_W'(i)) begin
        w_hit     = 1'b1;
        w_ro      = RO_MASK[i];
        bus_we[i] = commit & !RO_MASK[i];
      end
    end
  end

  always_comb begin
    r_hit = 1'b0;
    r_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        r_hit = 1'b1;
        r_mux = regs[i];
      end
    end
  end

  // NOTE: the register array is reset because its all-zero state is architecturally visible.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (bus_we[i])       regs[i] <= strb_merge(regs[i], w_data, w_strb);
        else if (hw_we_i[i]) regs[i] <= hw_wdata_i[i*32 +: 32];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_o[g*32 +: 32] = regs[g];
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s_bvalid   <= 1'b0;
      s_bresp    <= AXIL_RESP_OKAY;
      wr_pulse_o <= '0;
    end else begin
      wr_pulse_o <= bus_we;
      if (commit) begin
        s_bvalid <= 1'b1;
        s_bresp  <= (w_hit & !w_ro) ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
      end else if (s_bvalid & s_bready) begin
        s_bvalid <= 1'b0;
      end
    end
  end

  // Read data is captured from pre-edge register contents, so a same-edge commit is not visible.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= AXIL_RESP_OKAY;
    end else if (s_arvalid & s_arready) begin
      s_rvalid <= 1'b1;
      s_rdata  <= r_hit ? r_mux : '0;
      s_rresp  <= r_hit ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
    end else if (s_rvalid & s_rready) begin
      s_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cl_axil_csr_slave.sv
// Scenario-driven bench for cl_axil_csr_slave with queue-based expected
// responses and a local register model.
module tb_cl_axil_csr_slave;
  import cl_axil_csr_pkg::*;

  localparam int            NR = 16;
  localparam logic [NR-1:0] RO = 16'h0008;

  logic             aclk = 1'b0;
  logic             areset;
  logic [31:0]      s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]       s_wstrb;
  logic             s_awvalid, s_awready, s_wvalid, s_wready;
  logic [1:0]       s_bresp, s_rresp;
  logic             s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic [NR*32-1:0] regs_o, hw_wdata_i;
  logic [NR-1:0]    wr_pulse_o, hw_we_i;

  int errors = 0;
  int checks = 0;

  logic [1:0]  exp_b_q[$];
  logic [31:0] exp_rdata_q[$];
  logic [1:0]  exp_rresp_q[$];
  logic [31:0] model[NR];

  cl_axil_csr_slave #(.NUM_REGS(NR), .ADDR_WIDTH(12), .RO_MASK(RO)) dut (
    .aclk(aclk), .areset(areset),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o), .hw_we_i(hw_we_i), .hw_wdata_i(hw_wdata_i)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Full write with AW and W together and bready=1; returns the observed response.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp,
                           output logic [NR-1:0] pulses, output bit ok);
    bit aw_hs, w_hs;
    s_awaddr = addr; s_awvalid = 1'b1;
    s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1;
    s_bready = 1'b1;
    resp = 2'bxx; pulses = '0; ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      aw_hs = s_awvalid & s_awready;
      w_hs  = s_wvalid & s_wready;
      tick();
      if (aw_hs) s_awvalid = 1'b0;
      if (w_hs)  s_wvalid  = 1'b0;
      pulses |= wr_pulse_o;
      if (s_bvalid) begin
        resp = s_bresp;
        ok   = 1'b1;
      end
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    tick();
    pulses |= wr_pulse_o;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat, output bit ok);
    bit hs;
    s_araddr = addr; s_arvalid = 1'b1; s_rready = 1'b1;
    data = 'x; resp = 2'bxx; lat = 0; ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      hs = s_arvalid & s_arready;
      tick();
      if (hs) begin
        s_arvalid = 1'b0;
        lat = 1;
      end else if (!s_arvalid) begin
        lat++;
      end
      if (s_rvalid) begin
        data = s_rdata;
        resp = s_rresp;
        ok   = 1'b1;
      end
    end
    s_arvalid = 1'b0;
    tick();
    s_rready = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    hw_we_i = '0; hw_wdata_i = '0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    tick(); tick();
    checks++; if (s_awready !== 1'b0) begin errors++; $display("FAIL reset_awready: got %b expected 0", s_awready); end
    checks++; if (s_wready !== 1'b0) begin errors++; $display("FAIL reset_wready: got %b expected 0", s_wready); end
    checks++; if (s_arready !== 1'b0) begin errors++; $display("FAIL reset_arready: got %b expected 0", s_arready); end
    checks++; if (s_bvalid !== 1'b0 || s_rvalid !== 1'b0) begin errors++; $display("FAIL reset_valids: got b=%b r=%b expected 0", s_bvalid, s_rvalid); end
    checks++; if (s_bresp !== 2'b00 || s_rresp !== 2'b00 || s_rdata !== 32'h0) begin errors++; $display("FAIL reset_payload: got bresp=%b rresp=%b rdata=%h expected 0", s_bresp, s_rresp, s_rdata); end
    checks++; if (regs_o !== '0 || wr_pulse_o !== '0) begin errors++; $display("FAIL reset_regs: got pulse=%h regs=%h expected 0", wr_pulse_o, regs_o); end
    areset = 1'b0;
    tick();
    checks++; if ({s_awready, s_wready, s_arready} !== 3'b111) begin errors++; $display("FAIL reset_release_readies: got %b expected 111", {s_awready, s_wready, s_arready}); end
  endtask

  task automatic test_basic_write();
    logic [31:0] d; logic [1:0] r; int lat; bit ok;
    s_awaddr = 32'h008; s_awvalid = 1'b1;
    s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b1;
    exp_b_q.push_back(AXIL_RESP_OKAY);
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    checks++; if (s_bvalid !== 1'b0) begin errors++; $display("FAIL basic_bvalid_early: got %b expected 0", s_bvalid); end
    tick();
    model[2] = 32'hDEADBEEF;
    checks++; if (s_bvalid !== 1'b1) begin errors++; $display("FAIL basic_bvalid: got %b expected 1", s_bvalid); end
    checks++; if (s_bresp !== exp_b_q.pop_front()) begin errors++; $display("FAIL basic_bresp: got %b expected 00", s_bresp); end
    checks++; if (wr_pulse_o !== 16'h0004) begin errors++; $display("FAIL basic_pulse: got %h expected 0004", wr_pulse_o); end
    checks++; if (regs_o[2*32 +: 32] !== model[2]) begin errors++; $display("FAIL basic_reg2: got %h expected %h", regs_o[2*32 +: 32], model[2]); end
    tick();
    checks++; if (s_bvalid !== 1'b0 || wr_pulse_o !== '0) begin errors++; $display("FAIL basic_after_b: got bvalid=%b pulse=%h expected 0", s_bvalid, wr_pulse_o); end
    checks++; if (s_awready !== 1'b1 || s_wready !== 1'b1) begin errors++; $display("FAIL basic_readies_back: got aw=%b w=%b expected 1", s_awready, s_wready); end
    exp_rdata_q.push_back(32'hDEADBEEF); exp_rresp_q.push_back(AXIL_RESP_OKAY);
    bus_read(32'h008, d, r, lat, ok);
    checks++; if (!ok || lat != 1) begin errors++; $display("FAIL basic_read_latency: got ok=%0d lat=%0d expected lat 1", ok, lat); end
    checks++; if (d !== exp_rdata_q.pop_front()) begin errors++; $display("FAIL basic_read_data: got %h expected DEADBEEF", d); end
    checks++; if (r !== exp_rresp_q.pop_front()) begin errors++; $display("FAIL basic_read_resp: got %b expected 00", r); end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] r; logic [NR-1:0] p; bit ok;
    exp_b_q.push_back(AXIL_RESP_OKAY);
    bus_write(32'h004, 32'hFFFFFFFF, 4'hF, r, p, ok);
    model[1] = 32'hFFFFFFFF;
    checks++; if (!ok || r !== exp_b_q.pop_front()) begin errors++; $display("FAIL wfirst_setup: got ok=%0d resp=%b expected 00", ok, r); end
    s_wdata = 32'h11223344; s_wstrb = 4'b0101; s_wvalid = 1'b1; s_bready = 1'b1;
    tick();
    s_wvalid = 1'b0;
    checks++; if (s_wready !== 1'b0) begin errors++; $display("FAIL wfirst_wready_drop: got %b expected 0", s_wready); end
    tick(); tick();
    checks++; if (s_wready !== 1'b0 || s_bvalid !== 1'b0) begin errors++; $display("FAIL wfirst_waiting: got wready=%b bvalid=%b expected 0", s_wready, s_bvalid); end
    s_awaddr = 32'h004; s_awvalid = 1'b1;
    exp_b_q.push_back(AXIL_RESP_OKAY);
    tick();
    s_awvalid = 1'b0;
    tick();
    model[1] = 32'hFF22FF44;
    checks++; if (s_bvalid !== 1'b1 || s_bresp !== exp_b_q.pop_front()) begin errors++; $display("FAIL wfirst_b: got bvalid=%b bresp=%b expected 1/00", s_bvalid, s_bresp); end
    checks++; if (regs_o[1*32 +: 32] !== model[1]) begin errors++; $display("FAIL wfirst_merge: got %h expected %h", regs_o[1*32 +: 32], model[1]); end
    tick();
  endtask

  task automatic test_boundaries();
    logic [31:0] d; logic [1:0] r; logic [NR-1:0] p; int lat; bit ok;
    exp_b_q.push_back(AXIL_RESP_SLVERR);
    bus_write(32'h040, 32'h55555555, 4'hF, r, p, ok);
    checks++; if (!ok || r !== exp_b_q.pop_front()) begin errors++; $display("FAIL oor_write_resp: got ok=%0d resp=%b expected 10", ok, r); end
    checks++; if (p !== '0) begin errors++; $display("FAIL oor_write_pulse: got %h expected 0", p); end
    for (int i = 0; i < NR; i++) begin
      checks++; if (regs_o[i*32 +: 32] !== model[i]) begin errors++; $display("FAIL oor_reg%0d: got %h expected %h", i, regs_o[i*32 +: 32], model[i]); end
    end
    exp_rdata_q.push_back(32'h0); exp_rresp_q.push_back(AXIL_RESP_SLVERR);
    bus_read(32'hFFC, d, r, lat, ok);
    checks++; if (!ok || d !== exp_rdata_q.pop_front()) begin errors++; $display("FAIL oor_read_data: got ok=%0d data=%h expected 0", ok, d); end
    checks++; if (r !== exp_rresp_q.pop_front()) begin errors++; $display("FAIL oor_read_resp: got %b expected 10", r); end
    exp_b_q.push_back(AXIL_RESP_OKAY);
    bus_write(32'h008, 32'h00000000, 4'h0, r, p, ok);
    checks++; if (!ok || r !== exp_b_q.pop_front()) begin errors++; $display("FAIL zero_strb_resp: got ok=%0d resp=%b expected 00", ok, r); end
    checks++; if (p !== 16'h0004) begin errors++; $display("FAIL zero_strb_pulse: got %h expected 0004", p); end
    checks++; if (regs_o[2*32 +: 32] !== model[2]) begin errors++; $display("FAIL zero_strb_data: got %h expected %h", regs_o[2*32 +: 32], model[2]); end
  endtask

  task automatic test_read_only();
    logic [31:0] d; logic [1:0] r; logic [NR-1:0] p; int lat; bit ok;
    hw_wdata_i[3*32 +: 32] = 32'hA5A5A5A5; hw_we_i[3] = 1'b1;
    tick();
    hw_we_i = '0;
    model[3] = 32'hA5A5A5A5;
    checks++; if (regs_o[3*32 +: 32] !== model[3]) begin errors++; $display("FAIL ro_hw_load: got %h expected %h", regs_o[3*32 +: 32], model[3]); end
    exp_b_q.push_back(AXIL_RESP_SLVERR);
    bus_write(32'h00C, 32'h0, 4'hF, r, p, ok);
    checks++; if (!ok || r !== exp_b_q.pop_front()) begin errors++; $display("FAIL ro_write_resp: got ok=%0d resp=%b expected 10", ok, r); end
    checks++; if (p !== '0 || regs_o[3*32 +: 32] !== model[3]) begin errors++; $display("FAIL ro_write_effect: got pulse=%h reg3=%h expected 0/%h", p, regs_o[3*32 +: 32], model[3]); end
    exp_rdata_q.push_back(32'hA5A5A5A5); exp_rresp_q.push_back(AXIL_RESP_OKAY);
    bus_read(32'h00C, d, r, lat, ok);
    checks++; if (!ok || d !== exp_rdata_q.pop_front() || r !== exp_rresp_q.pop_front()) begin errors++; $display("FAIL ro_read: got ok=%0d data=%h resp=%b expected A5A5A5A5/00", ok, d, r); end
  endtask

  task automatic test_bready_stall();
    logic [1:0] r; logic [NR-1:0] p; bit ok;
    s_bready = 1'b0;
    s_awaddr = 32'h010; s_awvalid = 1'b1;
    s_wdata = 32'h12345678; s_wstrb = 4'hF; s_wvalid = 1'b1;
    exp_b_q.push_back(AXIL_RESP_OKAY);
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    tick();
    model[4] = 32'h12345678;
    for (int k = 0; k < 5; k++) begin
      checks++; if (s_bvalid !== 1'b1 || s_bresp !== AXIL_RESP_OKAY) begin errors++; $display("FAIL stall_b_stable[%0d]: got bvalid=%b bresp=%b expected 1/00", k, s_bvalid, s_bresp); end
      checks++; if (s_awready !== 1'b0 || s_wready !== 1'b0) begin errors++; $display("FAIL stall_readies[%0d]: got aw=%b w=%b expected 0", k, s_awready, s_wready); end
      tick();
    end
    checks++; if (s_bresp !== exp_b_q.pop_front() || regs_o[4*32 +: 32] !== model[4]) begin errors++; $display("FAIL stall_result: got bresp=%b reg4=%h expected 00/%h", s_bresp, regs_o[4*32 +: 32], model[4]); end
    s_bready = 1'b1;
    tick();
    checks++; if (s_awready !== 1'b1 || s_wready !== 1'b1 || s_bvalid !== 1'b0) begin errors++; $display("FAIL stall_release: got aw=%b w=%b bvalid=%b expected 1/1/0", s_awready, s_wready, s_bvalid); end
    exp_b_q.push_back(AXIL_RESP_OKAY);
    bus_write(32'h014, 32'hCAFEF00D, 4'hF, r, p, ok);
    model[5] = 32'hCAFEF00D;
    checks++; if (!ok || r !== exp_b_q.pop_front() || p !== 16'h0020) begin errors++; $display("FAIL stall_second_write: got ok=%0d resp=%b pulse=%h expected 00/0020", ok, r, p); end
    checks++; if (regs_o[5*32 +: 32] !== model[5]) begin errors++; $display("FAIL stall_second_data: got %h expected %h", regs_o[5*32 +: 32], model[5]); end
  endtask

  task automatic test_collisions();
    s_awaddr = 32'h008; s_awvalid = 1'b1;
    s_wdata = 32'h01020304; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b1;
    exp_b_q.push_back(AXIL_RESP_OKAY);
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    s_araddr = 32'h008; s_arvalid = 1'b1; s_rready = 1'b0;
    hw_wdata_i[2*32 +: 32] = 32'h99999999; hw_we_i[2] = 1'b1;
    exp_rdata_q.push_back(model[2]); exp_rresp_q.push_back(AXIL_RESP_OKAY);
    tick();
    s_arvalid = 1'b0; hw_we_i = '0;
    model[2] = 32'h01020304;
    checks++; if (s_bvalid !== 1'b1 || s_bresp !== exp_b_q.pop_front()) begin errors++; $display("FAIL coll_b: got bvalid=%b bresp=%b expected 1/00", s_bvalid, s_bresp); end
    checks++; if (s_rvalid !== 1'b1 || s_rdata !== exp_rdata_q.pop_front() || s_rresp !== exp_rresp_q.pop_front()) begin errors++; $display("FAIL coll_read_old: got rvalid=%b rdata=%h rresp=%b expected 1/DEADBEEF/00", s_rvalid, s_rdata, s_rresp); end
    checks++; if (regs_o[2*32 +: 32] !== model[2]) begin errors++; $display("FAIL coll_bus_wins: got %h expected %h", regs_o[2*32 +: 32], model[2]); end
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
    checks++; if (s_bvalid !== 1'b0 || s_rvalid !== 1'b0) begin errors++; $display("FAIL coll_drain: got bvalid=%b rvalid=%b expected 0", s_bvalid, s_rvalid); end
  endtask

  task automatic test_back_to_back();
    int n_hs = 0;
    s_araddr = 32'h004; s_arvalid = 1'b1; s_rready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (s_arready) begin
        n_hs++;
        exp_rdata_q.push_back(model[1]);
        exp_rresp_q.push_back(AXIL_RESP_OKAY);
      end
      tick();
      if (s_rvalid) begin
        checks++; if (s_rdata !== exp_rdata_q.pop_front() || s_rresp !== exp_rresp_q.pop_front()) begin errors++; $display("FAIL b2b_data[%0d]: got %h/%b expected %h/00", c, s_rdata, s_rresp, model[1]); end
      end
    end
    s_arvalid = 1'b0;
    tick();
    s_rready = 1'b0;
    checks++; if (n_hs != 4 || exp_rdata_q.size() != 0) begin errors++; $display("FAIL b2b_rate: got %0d reads (%0d unanswered) expected 4 (0)", n_hs, exp_rdata_q.size()); end
  endtask

  task automatic test_reset_mid();
    s_araddr = 32'h008; s_arvalid = 1'b1; s_rready = 1'b0;
    tick();
    s_arvalid = 1'b0;
    checks++; if (s_rvalid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_rvalid: got %b expected 1", s_rvalid); end
    s_awaddr = 32'h000; s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    checks++; if (s_awready !== 1'b0) begin errors++; $display("FAIL rstmid_aw_held: got %b expected 0", s_awready); end
    #2 areset = 1'b1;
    #1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    checks++; if (s_rvalid !== 1'b0 || s_bvalid !== 1'b0) begin errors++; $display("FAIL rstmid_valids: got rvalid=%b bvalid=%b expected 0", s_rvalid, s_bvalid); end
    checks++; if (regs_o !== '0) begin errors++; $display("FAIL rstmid_regs: got %h expected 0", regs_o); end
    tick(); tick();
    areset = 1'b0;
    tick();
    checks++; if ({s_awready, s_wready, s_arready} !== 3'b111) begin errors++; $display("FAIL rstmid_readies: got %b expected 111", {s_awready, s_wready, s_arready}); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (s_bvalid !== 1'b0 || s_awready !== 1'b1) begin errors++; $display("FAIL rstmid_no_stale_b[%0d]: got bvalid=%b awready=%b expected 0/1", k, s_bvalid, s_awready); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_w_before_aw();
    test_boundaries();
    test_read_only();
    test_bready_stall();
    test_collisions();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
